// File: rtl/stage_link_fifo.sv
// Elastic link between two RMT stages: independent PHV and VLAN queues with early
// back-pressure, plus a one-register slice on the control-path AXI-Stream.

module link_queue #(
  parameter int WIDTH     = 12,
  parameter int DEPTH_LOG = 2,
  parameter int SLACK     = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_valid,
  output logic                 ready_out,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 ready_in,
  output logic [DEPTH_LOG:0]   count,
  output logic                 overflow
);
  localparam int DEPTH = 1 << DEPTH_LOG;
  localparam logic [DEPTH_LOG:0] FULL_COUNT  = (DEPTH_LOG+1)'(DEPTH);
  localparam logic [DEPTH_LOG:0] READY_LIMIT = (DEPTH_LOG+1)'(DEPTH - SLACK);

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [DEPTH_LOG-1:0] wr_ptr_reg, wr_ptr_next;
  logic [DEPTH_LOG-1:0] rd_ptr_reg, rd_ptr_next;
  logic [DEPTH_LOG:0]   count_reg, count_next;
  logic [WIDTH-1:0]     out_data_reg, head_next;
  logic                 out_valid_reg, ready_reg, overflow_reg;
  logic                 full, pop, push, drop, bypass;

  // in_valid is deliberately not gated by ready_out: upstream keeps emitting under back-pressure.
  assign full = (count_reg == FULL_COUNT);
  assign pop  = out_valid_reg && ready_in;
  assign push = in_valid && (!full || pop);
  assign drop = in_valid && full && !pop;

  always_comb begin
    wr_ptr_next = push ? wr_ptr_reg + 1'b1 : wr_ptr_reg;
    rd_ptr_next = pop  ? rd_ptr_reg + 1'b1 : rd_ptr_reg;
    count_next  = count_reg;
    if (push && !pop)
      count_next = count_reg + 1'b1;
    else if (pop && !push)
      count_next = count_reg - 1'b1;
    // The incoming word becomes the head when nothing older remains after this pop.
    bypass    = push && (wr_ptr_reg == rd_ptr_next);
    head_next = bypass ? in_data : mem[rd_ptr_next];
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_reg] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      ready_reg     <= 1'b1;
      overflow_reg  <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      out_data_reg  <= head_next;
      out_valid_reg <= (count_next != '0);
      ready_reg     <= (count_next < READY_LIMIT);
      overflow_reg  <= overflow_reg | drop;
    end
  end

  assign ready_out = ready_reg;
  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;
  assign count     = count_reg;
  assign overflow  = overflow_reg;
endmodule

module stage_link_fifo #(
  parameter int C_S_AXIS_DATA_WIDTH  = 512,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int NUM_PER_TYPE         = 8,
  parameter int PHV_LEN              = 48*NUM_PER_TYPE + 32*NUM_PER_TYPE + 16*NUM_PER_TYPE + 256,
  parameter int C_VLANID_WIDTH       = 12,
  parameter int PHV_DEPTH_LOG        = 2,
  parameter int VLAN_DEPTH_LOG       = 3,
  parameter int SLACK                = 2
) (
  input  logic                              axis_clk,
  input  logic                              aresetn,
  input  logic [PHV_LEN-1:0]                phv_in,
  input  logic                              phv_in_valid,
  output logic                              phv_ready_out,
  input  logic [C_VLANID_WIDTH-1:0]         vlan_in,
  input  logic                              vlan_in_valid,
  output logic                              vlan_ready_out,
  output logic [PHV_LEN-1:0]                phv_out,
  output logic                              phv_out_valid,
  input  logic                              phv_ready_in,
  output logic [C_VLANID_WIDTH-1:0]         vlan_out,
  output logic                              vlan_out_valid,
  input  logic                              vlan_ready_in,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    c_s_axis_tdata,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_s_axis_tuser,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_s_axis_tkeep,
  input  logic                              c_s_axis_tvalid,
  input  logic                              c_s_axis_tlast,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]    c_m_axis_tdata,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_m_axis_tuser,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_m_axis_tkeep,
  output logic                              c_m_axis_tvalid,
  output logic                              c_m_axis_tlast,
  output logic [PHV_DEPTH_LOG:0]            phv_count,
  output logic [VLAN_DEPTH_LOG:0]           vlan_count,
  output logic [1:0]                        overflow_err
);
  logic phv_overflow, vlan_overflow;

  link_queue #(.WIDTH(PHV_LEN), .DEPTH_LOG(PHV_DEPTH_LOG), .SLACK(SLACK)) phv_queue (
    .clk(axis_clk), .resetn(aresetn),
    .in_data(phv_in), .in_valid(phv_in_valid), .ready_out(phv_ready_out),
    .out_data(phv_out), .out_valid(phv_out_valid), .ready_in(phv_ready_in),
    .count(phv_count), .overflow(phv_overflow)
  );

  link_queue #(.WIDTH(C_VLANID_WIDTH), .DEPTH_LOG(VLAN_DEPTH_LOG), .SLACK(SLACK)) vlan_queue (
    .clk(axis_clk), .resetn(aresetn),
    .in_data(vlan_in), .in_valid(vlan_in_valid), .ready_out(vlan_ready_out),
    .out_data(vlan_out), .out_valid(vlan_out_valid), .ready_in(vlan_ready_in),
    .count(vlan_count), .overflow(vlan_overflow)
  );

  assign overflow_err = {vlan_overflow, phv_overflow};

  // Control path has no back-pressure, so a plain register stage is sufficient.
  always_ff @(posedge axis_clk) begin
    if (!aresetn) begin
      c_m_axis_tdata  <= '0;
      c_m_axis_tuser  <= '0;
      c_m_axis_tkeep  <= '0;
      c_m_axis_tvalid <= 1'b0;
      c_m_axis_tlast  <= 1'b0;
    end else begin
      c_m_axis_tdata  <= c_s_axis_tdata;
      c_m_axis_tuser  <= c_s_axis_tuser;
      c_m_axis_tkeep  <= c_s_axis_tkeep;
      c_m_axis_tvalid <= c_s_axis_tvalid;
      c_m_axis_tlast  <= c_s_axis_tlast;
    end
  end
endmodule

// File: tb/tb_stage_link_fifo.sv
// Bench for stage_link_fifo: reference queues track accepted words, plus a per-cycle
// vector table and hand-written sequences for overflow, wrap, reset and control path.

module tb_stage_link_fifo;
  localparam int DW  = 512;
  localparam int UW  = 128;
  localparam int NPT = 8;
  localparam int PL  = 48*NPT + 32*NPT + 16*NPT + 256;
  localparam int VW  = 12;

  logic              axis_clk;
  logic              aresetn;
  logic [PL-1:0]     phv_in, phv_out;
  logic              phv_in_valid, phv_ready_out, phv_out_valid, phv_ready_in;
  logic [VW-1:0]     vlan_in, vlan_out;
  logic              vlan_in_valid, vlan_ready_out, vlan_out_valid, vlan_ready_in;
  logic [DW-1:0]     c_s_axis_tdata, c_m_axis_tdata;
  logic [UW-1:0]     c_s_axis_tuser, c_m_axis_tuser;
  logic [DW/8-1:0]   c_s_axis_tkeep, c_m_axis_tkeep;
  logic              c_s_axis_tvalid, c_m_axis_tvalid, c_s_axis_tlast, c_m_axis_tlast;
  logic [2:0]        phv_count;
  logic [3:0]        vlan_count;
  logic [1:0]        overflow_err;

  stage_link_fifo #(
    .C_S_AXIS_DATA_WIDTH(DW), .C_S_AXIS_TUSER_WIDTH(UW), .NUM_PER_TYPE(NPT),
    .PHV_LEN(PL), .C_VLANID_WIDTH(VW), .PHV_DEPTH_LOG(2), .VLAN_DEPTH_LOG(3), .SLACK(2)
  ) dut (
    .axis_clk(axis_clk), .aresetn(aresetn),
    .phv_in(phv_in), .phv_in_valid(phv_in_valid), .phv_ready_out(phv_ready_out),
    .vlan_in(vlan_in), .vlan_in_valid(vlan_in_valid), .vlan_ready_out(vlan_ready_out),
    .phv_out(phv_out), .phv_out_valid(phv_out_valid), .phv_ready_in(phv_ready_in),
    .vlan_out(vlan_out), .vlan_out_valid(vlan_out_valid), .vlan_ready_in(vlan_ready_in),
    .c_s_axis_tdata(c_s_axis_tdata), .c_s_axis_tuser(c_s_axis_tuser),
    .c_s_axis_tkeep(c_s_axis_tkeep), .c_s_axis_tvalid(c_s_axis_tvalid),
    .c_s_axis_tlast(c_s_axis_tlast),
    .c_m_axis_tdata(c_m_axis_tdata), .c_m_axis_tuser(c_m_axis_tuser),
    .c_m_axis_tkeep(c_m_axis_tkeep), .c_m_axis_tvalid(c_m_axis_tvalid),
    .c_m_axis_tlast(c_m_axis_tlast),
    .phv_count(phv_count), .vlan_count(vlan_count), .overflow_err(overflow_err)
  );

  initial axis_clk = 1'b0;
  always #5 axis_clk = ~axis_clk;

  typedef struct {
    logic       pv;
    logic [7:0] pd;
    logic       pr;
    logic       vv;
    logic [11:0] vd;
    logic       vr;
    int         exp_pc;
    int         exp_vc;
    int         exp_ovf;
  } vec_t;

  vec_t           vecs[$];
  logic [PL-1:0]  phv_exp[$];
  logic [VW-1:0]  vlan_exp[$];
  logic [1:0]     m_ovf;
  int             n_vec  = 0;
  int             n_fail = 0;

  function automatic vec_t mk(logic pv, logic [7:0] pd, logic pr, logic vv, logic [11:0] vd,
                              logic vr, int pc, int vc, int ovf);
    vec_t v;
    v.pv = pv; v.pd = pd; v.pr = pr; v.vv = vv; v.vd = vd; v.vr = vr;
    v.exp_pc = pc; v.exp_vc = vc; v.exp_ovf = ovf;
    return v;
  endfunction

  task automatic chk_n(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_w(string name, logic [1023:0] act, logic [1023:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got ..%0h expected ..%0h at %0t", name, act[191:0], exp[191:0], $time);
    end
  endtask

  // One clock: score pops/pushes implied by the current inputs, clock, then check occupancy.
  task automatic tick();
    logic p_pop, v_pop;
    logic [PL-1:0] pe;
    logic [VW-1:0] ve;
    if (aresetn) begin
      p_pop = phv_out_valid && phv_ready_in;
      v_pop = vlan_out_valid && vlan_ready_in;
      if (p_pop) begin
        if (phv_exp.size() == 0) chk_n("phv_pop_unexpected", 1, 0);
        else begin pe = phv_exp.pop_front(); chk_w("phv_out", 1024'(phv_out), 1024'(pe)); end
      end
      if (phv_in_valid) begin
        if (phv_exp.size() < 4) phv_exp.push_back(phv_in);
        else m_ovf[0] = 1'b1;
      end
      if (v_pop) begin
        if (vlan_exp.size() == 0) chk_n("vlan_pop_unexpected", 1, 0);
        else begin ve = vlan_exp.pop_front(); chk_n("vlan_out", int'(vlan_out), int'(ve)); end
      end
      if (vlan_in_valid) begin
        if (vlan_exp.size() < 8) vlan_exp.push_back(vlan_in);
        else m_ovf[1] = 1'b1;
      end
    end
    @(posedge axis_clk);
    #1;
    if (!aresetn) begin
      phv_exp.delete();
      vlan_exp.delete();
      m_ovf = 2'b00;
    end
    chk_n("phv_count", int'(phv_count), phv_exp.size());
    chk_n("vlan_count", int'(vlan_count), vlan_exp.size());
    chk_n("phv_out_valid", int'(phv_out_valid), int'(phv_exp.size() != 0));
    chk_n("vlan_out_valid", int'(vlan_out_valid), int'(vlan_exp.size() != 0));
    chk_n("phv_ready_out", int'(phv_ready_out), int'(phv_exp.size() < 2));
    chk_n("vlan_ready_out", int'(vlan_ready_out), int'(vlan_exp.size() < 6));
    chk_n("overflow_err", int'(overflow_err), int'(m_ovf));
  endtask

  task automatic idle_inputs();
    phv_in_valid = 1'b0; phv_in = '0; phv_ready_in = 1'b0;
    vlan_in_valid = 1'b0; vlan_in = '0; vlan_ready_in = 1'b0;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
  endtask

  initial begin
    m_ovf = 2'b00;
    idle_inputs();
    c_s_axis_tdata = '0; c_s_axis_tuser = '0; c_s_axis_tkeep = '0;
    c_s_axis_tvalid = 1'b0; c_s_axis_tlast = 1'b0;
    aresetn = 1'b0;
    tick();
    tick();
    chk_w("rst_phv_out", 1024'(phv_out), '0);
    chk_n("rst_vlan_out", int'(vlan_out), 0);
    chk_n("rst_c_tvalid", int'(c_m_axis_tvalid), 0);
    chk_w("rst_c_tdata", 1024'(c_m_axis_tdata), '0);
    aresetn = 1'b1;

    // Single transfer, PHV stall/overflow/drain, VLAN overflow/drain.
    vecs.push_back(mk(1, 8'hA5, 1, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 0, 0));
    for (int i = 1; i <= 5; i++)
      vecs.push_back(mk(1, 8'(i), 0, 0, 0, 0, (i < 4) ? i : 4, 0, (i == 5) ? 1 : 0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0, 3 - i, 0, 1));
    for (int i = 1; i <= 9; i++)
      vecs.push_back(mk(0, 8'h00, 0, 1, 12'(i), 0, 0, (i < 8) ? i : 8, (i == 9) ? 3 : 1));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(0, 8'h00, 0, 0, 12'h000, 1, 0, 7 - i, 3));

    for (int i = 0; i < vecs.size(); i++) begin
      phv_in_valid  = vecs[i].pv;
      phv_in        = {128{vecs[i].pd}};
      phv_ready_in  = vecs[i].pr;
      vlan_in_valid = vecs[i].vv;
      vlan_in       = vecs[i].vd;
      vlan_ready_in = vecs[i].vr;
      tick();
      chk_n("vec_phv_count", int'(phv_count), vecs[i].exp_pc);
      chk_n("vec_vlan_count", int'(vlan_count), vecs[i].exp_vc);
      chk_n("vec_overflow", int'(overflow_err), vecs[i].exp_ovf);
      if (i == 0) chk_w("vec_first_phv", 1024'(phv_out), 1024'({128{8'hA5}}));
      if (i == 3) chk_n("vec_ready_fell", int'(phv_ready_out), 0);
    end
    idle_inputs();

    // Full queue with simultaneous read and write across many pointer wraps.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      phv_in_valid = 1'b1; phv_in = {32{32'(k)}};
      tick();
    end
    chk_n("full_count", int'(phv_count), 4);
    phv_ready_in = 1'b1;
    for (int k = 4; k < 24; k++) begin
      phv_in = {32{32'(k)}};
      tick();
      chk_n("full_rw_count", int'(phv_count), 4);
      chk_n("full_rw_no_drop", int'(overflow_err), 0);
    end
    phv_in_valid = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk_n("full_drained", int'(phv_count), 0);
    idle_inputs();

    // VLANs flow while PHVs are stalled, then reset mid-stream.
    do_reset();
    vlan_ready_in = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      vlan_in_valid = 1'b1; vlan_in = 12'(k);
      phv_in_valid = 1'b1; phv_in = {128{8'(k + 16)}};
      tick();
      chk_n("indep_vlan_out", int'(vlan_out), k);
      chk_n("indep_vlan_valid", int'(vlan_out_valid), 1);
    end
    vlan_in_valid = 1'b0; phv_in_valid = 1'b0;
    tick();
    chk_n("indep_vlan_done", int'(vlan_out_valid), 0);
    chk_n("indep_phv_held", int'(phv_count), 3);
    vlan_in_valid = 1'b1; phv_in_valid = 1'b1;
    aresetn = 1'b0;
    tick();
    chk_n("midrst_phv_valid", int'(phv_out_valid), 0);
    chk_n("midrst_vlan_valid", int'(vlan_out_valid), 0);
    chk_n("midrst_phv_count", int'(phv_count), 0);
    chk_n("midrst_vlan_count", int'(vlan_count), 0);
    chk_n("midrst_overflow", int'(overflow_err), 0);
    chk_w("midrst_phv_out", 1024'(phv_out), '0);
    aresetn = 1'b1;
    idle_inputs();
    tick();

    // Control path: exactly one register of delay, no filtering.
    c_s_axis_tvalid = 1'b1; c_s_axis_tdata = 512'h1234; c_s_axis_tlast = 1'b1;
    c_s_axis_tuser = 128'hBEEF; c_s_axis_tkeep = '1;
    chk_n("ctrl_not_early", int'(c_m_axis_tvalid), 0);
    tick();
    c_s_axis_tvalid = 1'b0; c_s_axis_tdata = '0; c_s_axis_tlast = 1'b0;
    c_s_axis_tuser = '0; c_s_axis_tkeep = '0;
    chk_n("ctrl_tvalid", int'(c_m_axis_tvalid), 1);
    chk_w("ctrl_tdata", 1024'(c_m_axis_tdata), 1024'(512'h1234));
    chk_n("ctrl_tlast", int'(c_m_axis_tlast), 1);
    chk_w("ctrl_tuser", 1024'(c_m_axis_tuser), 1024'(128'hBEEF));
    chk_w("ctrl_tkeep", 1024'(c_m_axis_tkeep), 1024'({64{1'b1}}));
    tick();
    chk_n("ctrl_tvalid_off", int'(c_m_axis_tvalid), 0);
    chk_n("ctrl_tlast_off", int'(c_m_axis_tlast), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
